dmem_refill: RTL and testbench
==============================

// Module: dmem_refill
// PURPOSE
//  Memory-side responder for data-cache misses. Accepts a miss on either cache port and reads
//  the 16-word (64-byte) block from a word-wide backing RAM, one word per cycle after a fixed
//  access delay. Returns the block on WM1/WM2 with a one-cycle READY pulse. Also takes the
//  pipeline's write-through stores. Sits between the data cache and main memory.
// PARAMETERS
//  DEPTH_WORDS  16384  backing RAM size in 32-bit words (power of 2)
//  WAIT_CYC     4      access-delay cycles before burst; total miss-to-READY = WAIT_CYC+16 = 20
// PORTS
//  clk    in   1    single clock; all state updates on posedge
//  rst    in   1    asynchronous, active-high reset
//  req1   in   1    port-1 miss; held high until serviced
//  req2   in   1    port-2 miss; held high until serviced
//  A1     in   32   port-1 miss address; block base = A1[31:6]
//  A2     in   32   port-2 miss address
//  WE     in   1    store write-through enable
//  WA     in   32   store byte address; word index = WA[log2(DEPTH_WORDS)+1:2]
//  WD     in   32   store data
//  WM1    out  512  block for port 1; word i at [32i+31:32i]
//  WM2    out  512  block for port 2
//  READY  out  1    one-cycle pulse: the granted WMx holds the complete block
//  busy   out  1    high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; READY=0; busy=0; WM1=WM2=0; counters=0. RAM contents are not cleared.
//    Reset asserted mid-fill aborts the fill; no partial block is ever flagged READY.
//  - FSM: IDLE -> WAIT -> BURST -> DONE -> IDLE.
//  - IDLE: on posedge with req1|req2, latch grant (req1 wins ties) and the block base,
//    then go to WAIT.
//  - WAIT: count WAIT_CYC edges, then go to BURST. WAIT_CYC=0 goes straight to BURST.
//  - BURST: each edge captures RAM[{base,cnt[3:0]}] into line word cnt, then cnt++.
//    After word 15, go to DONE.
//  - Capture edges are WAIT_CYC+1 .. WAIT_CYC+16. READY rises after edge WAIT_CYC+16.
//  - DONE: registered READY=1 for exactly one cycle. The granted WMx is updated from the line
//    buffer in the same edge; the other WMx holds its value. Requests are ignored in DONE.
//  - Return to IDLE after DONE. A request still high in IDLE starts a new fill next edge.
//  - WMx hold their value until their next fill completes.
//  - A losing request stays pending and is serviced after the current fill.
//  - Req deasserting mid-fill does not abort. The fill completes and READY still pulses.
//  - Stores: RAM[WA idx] <= WD on any posedge with WE, in every state.
//  - Store and burst read of the same word in the same edge: the read returns the OLD word
//    (read-before-write).
//  - Address bits above the RAM index are ignored (aliasing, no error).
// CONFIGURATION
//  DMEM_REFILL_WRITE_FWD_EN defined:
//    - A store whose WA[31:6] equals the latched base while busy also patches line-buffer
//      word WA[5:2], including words already captured.
//    - Same-edge store to the word being captured: the store data wins.
//    - The delivered block never misses a store issued during its fill.
//  Undefined: the line buffer takes only RAM reads. Stores to words already captured are
//    absent from the delivered block.
// STRUCTURE
//  - Shared defines header dmem_defs.vh: WORDS_PER_BLOCK=16, BLOCK_BITS=512, OFFSET_BITS=6,
//    WORD_BITS=32, FSM state encodings (S_IDLE/S_WAIT/S_BURST/S_DONE).
//  - One sub-module dmem_line_buf: 16x32 register file with a capture write port and a patch
//    write port (patch has priority), and a flat 512-bit read-out.
//  - FSM, counters, arbitration and RAM live in dmem_refill.
// TESTING
//  1. RAM[k]=k for k=0..31; req1=1, A1=0x40, hold.
//     -> READY one cycle, 20 cycles after the sampling edge; WM1 word i = 16+i; WM2 unchanged.
//  2. req1 and req2 in the same edge, A1=0x0, A2=0x80.
//     -> port-1 block delivered first (READY#1, WM1).
//     -> READY#2 follows 22 cycles after READY#1 (DONE + IDLE); WM2 = words 32..47.
//  3. rst pulsed at cycle 10 of a fill.
//     -> READY never asserts for that fill; busy=0 and WM1=0 immediately.
//     -> a re-issued req completes normally.
//  4. During fill of 0x40: WE, WA=0x44, WD=0xDEADBEEF issued after word 1 was captured.
//     -> FWD_EN: WM1 word 1 = 0xDEADBEEF. Undefined: word 1 = 17. RAM[17] = 0xDEADBEEF in both.
//  5. Same-edge store and burst capture to word 5.
//     -> without FWD_EN word 5 = old value; with FWD_EN word 5 = store data.
//  6. WAIT_CYC=0 build, A1=0x0.
//     -> READY after 16 cycles; req dropped at cycle 3 still yields READY with the full block.

Source files
------------

// File: rtl/dmem_refill_pkg.sv
// -----------------------------------------------------------------------------
// dmem_refill_pkg
// Shared constants and types for the data-cache refill responder.
//   WORDS_PER_BLOCK / WORD_BITS / BLOCK_BITS / OFFSET_BITS : block geometry
//   fill_state_e : refill FSM states (IDLE -> WAIT -> BURST -> DONE)
//   grant_e      : which cache port owns the fill in progress
//   word_of / block_of : split a byte address into word-in-block and block base
// -----------------------------------------------------------------------------
package dmem_refill_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int WORD_BITS       = 32;
    localparam int BLOCK_BITS      = WORDS_PER_BLOCK * WORD_BITS;  // 512
    localparam int OFFSET_BITS     = 6;                            // 64-byte block
    localparam int WIDX_BITS       = 4;                            // word within block
    localparam int BASE_BITS       = 32 - OFFSET_BITS;             // A[31:6]

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } fill_state_e;

    typedef enum logic {
        GRANT_P1 = 1'b0,
        GRANT_P2 = 1'b1
    } grant_e;

    // Word index inside the 64-byte block.
    function automatic logic [WIDX_BITS-1:0] word_of(input logic [31:0] addr);
        return addr[OFFSET_BITS-1:2];
    endfunction

    // Block base address (byte address with the block offset stripped).
    function automatic logic [BASE_BITS-1:0] block_of(input logic [31:0] addr);
        return addr[31:OFFSET_BITS];
    endfunction

endpackage

// File: rtl/dmem_refill_if.sv
// -----------------------------------------------------------------------------
// dmem_refill_if
// Bundle between the data cache / pipeline (master) and the refill responder
// (slave).
//   req1, A1 / req2, A2 : miss requests and miss addresses for cache ports 1/2
//   WE, WA, WD          : write-through store from the pipeline
//   WM1, WM2            : delivered 512-bit blocks, word i at [32i+31:32i]
//   READY               : one-cycle pulse, granted WMx holds a complete block
//   busy                : responder is not idle
// -----------------------------------------------------------------------------
interface dmem_refill_if;
    import dmem_refill_pkg::*;

    logic                  req1;
    logic                  req2;
    logic [31:0]           A1;
    logic [31:0]           A2;
    logic                  WE;
    logic [31:0]           WA;
    logic [31:0]           WD;
    logic [BLOCK_BITS-1:0] WM1;
    logic [BLOCK_BITS-1:0] WM2;
    logic                  READY;
    logic                  busy;

    modport master (
        output req1, req2, A1, A2, WE, WA, WD,
        input  WM1, WM2, READY, busy
    );

    modport slave (
        input  req1, req2, A1, A2, WE, WA, WD,
        output WM1, WM2, READY, busy
    );

endinterface

// File: rtl/dmem_line_buf.sv
// -----------------------------------------------------------------------------
// dmem_line_buf
// 16 x 32-bit line buffer that assembles a block during a refill burst.
//   clk, rst                         : clock, asynchronous active-high reset
//   cap_en, cap_idx, cap_data        : capture port (word read from RAM)
//   patch_en, patch_idx, patch_data  : patch port (store forwarding); wins over
//                                      a capture to the same word in one edge
//   line_next                        : flat 512-bit view of the contents the
//                                      buffer will hold after the current edge
// Exposing the post-edge contents lets the top deliver the block on the same
// edge that captures the last word.
// -----------------------------------------------------------------------------
module dmem_line_buf
    import dmem_refill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic [WIDX_BITS-1:0]  cap_idx,
    input  logic [WORD_BITS-1:0]  cap_data,
    input  logic                  patch_en,
    input  logic [WIDX_BITS-1:0]  patch_idx,
    input  logic [WORD_BITS-1:0]  patch_data,
    output logic [BLOCK_BITS-1:0] line_next
);

    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
            logic [WORD_BITS-1:0] word_reg;
            logic [WORD_BITS-1:0] word_next;

            always_comb begin
                word_next = word_reg;
                if (cap_en && (cap_idx == WIDX_BITS'(gi))) begin
                    word_next = cap_data;
                end
                // Patch is applied last so a same-edge store overrides the capture.
                if (patch_en && (patch_idx == WIDX_BITS'(gi))) begin
                    word_next = patch_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                end else begin
                    word_reg <= word_next;
                end
            end

            assign line_next[gi*WORD_BITS +: WORD_BITS] = word_next;
        end
    endgenerate

endmodule

// File: rtl/dmem_refill.sv
// -----------------------------------------------------------------------------
// dmem_refill
// Memory-side responder for data-cache misses. Arbitrates two miss ports
// (port 1 wins ties), waits WAIT_CYC cycles, then bursts the 16-word block out
// of a word-wide backing RAM, one word per cycle, and delivers it on WM1/WM2
// with a one-cycle READY pulse. Write-through stores update the RAM every cycle.
//   Parameters : DEPTH_WORDS (RAM words, power of 2), WAIT_CYC (access delay)
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : dmem_refill_if.slave (requests, stores, WM1/WM2, READY, busy)
// Build option: define DMEM_REFILL_WRITE_FWD_EN to forward stores that hit the
// block being filled into the line buffer, so the delivered block is never
// stale with respect to stores issued during its fill.
// -----------------------------------------------------------------------------
module dmem_refill
    import dmem_refill_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int WAIT_CYC    = 4
) (
    input  logic         clk,
    input  logic         rst,
    dmem_refill_if.slave bus
);

    localparam int IDX_BITS      = $clog2(DEPTH_WORDS);
    localparam int BASE_IDX_BITS = IDX_BITS - WIDX_BITS;
    localparam int WCNT_BITS     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WCNT_BITS-1:0] WAIT_LAST =
        WCNT_BITS'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

    fill_state_e            state_reg, state_next;
    grant_e                 grant_reg, grant_next;
    logic [BASE_BITS-1:0]   base_reg, base_next;
    logic [WCNT_BITS-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [WIDX_BITS-1:0]   word_cnt_reg, word_cnt_next;
    logic                   ready_reg;
    logic [BLOCK_BITS-1:0]  wm1_reg, wm2_reg;

    logic                   cap_en;
    logic                   last_capture;
    logic                   patch_en;
    logic [BLOCK_BITS-1:0]  line_next;

    // ------------------------------------------------------------------
    // Backing RAM. Contents survive reset. The burst read is asynchronous
    // and lands in the line-buffer register, so a same-edge store to the
    // word being captured returns the old word (read-before-write).
    // ------------------------------------------------------------------
    logic [WORD_BITS-1:0] ram [DEPTH_WORDS];
    logic [IDX_BITS-1:0]  rd_idx;
    logic [IDX_BITS-1:0]  wr_idx;
    logic [WORD_BITS-1:0] rd_data;

    // Address bits above the RAM index are dropped: addresses alias.
    assign rd_idx  = {base_reg[BASE_IDX_BITS-1:0], word_cnt_reg};
    assign wr_idx  = bus.WA[IDX_BITS+1:2];
    assign rd_data = ram[rd_idx];

    always_ff @(posedge clk) begin
        if (bus.WE) begin
            ram[wr_idx] <= bus.WD;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            grant_reg    <= GRANT_P1;
            base_reg     <= '0;
            wait_cnt_reg <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            base_reg     <= base_next;
            wait_cnt_reg <= wait_cnt_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        base_next     = base_reg;
        wait_cnt_next = wait_cnt_reg;
        word_cnt_next = word_cnt_reg;
        cap_en        = 1'b0;
        last_capture  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.req1 || bus.req2) begin
                    grant_next    = bus.req1 ? GRANT_P1 : GRANT_P2;
                    base_next     = bus.req1 ? block_of(bus.A1) : block_of(bus.A2);
                    wait_cnt_next = '0;
                    word_cnt_next = '0;
                    // A zero access delay skips WAIT so the first capture is
                    // on the very next edge.
                    state_next    = (WAIT_CYC == 0) ? S_BURST : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = S_BURST;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_BURST: begin
                cap_en        = 1'b1;
                word_cnt_next = word_cnt_reg + 1'b1;
                if (word_cnt_reg == WIDX_BITS'(WORDS_PER_BLOCK - 1)) begin
                    last_capture = 1'b1;
                    state_next   = S_DONE;
                end
            end
            S_DONE: begin
                // Requests are ignored here; a held request starts the next
                // fill from IDLE one edge later.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store forwarding into the line buffer
    // ------------------------------------------------------------------
`ifdef DMEM_REFILL_WRITE_FWD_EN
    assign patch_en = bus.WE && (state_reg != S_IDLE) && (block_of(bus.WA) == base_reg);
`else
    assign patch_en = 1'b0;
`endif

    dmem_line_buf u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .cap_en     (cap_en),
        .cap_idx    (word_cnt_reg),
        .cap_data   (rd_data),
        .patch_en   (patch_en),
        .patch_idx  (word_of(bus.WA)),
        .patch_data (bus.WD),
        .line_next  (line_next)
    );

    // ------------------------------------------------------------------
    // Delivery: the granted WMx is loaded on the last capture edge from the
    // post-edge line contents, and READY is registered alongside it, so
    // READY is high exactly during DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_reg <= 1'b0;
            wm1_reg   <= '0;
            wm2_reg   <= '0;
        end else begin
            ready_reg <= last_capture;
            if (last_capture) begin
                if (grant_reg == GRANT_P1) begin
                    wm1_reg <= line_next;
                end else begin
                    wm2_reg <= line_next;
                end
            end
        end
    end

    assign bus.WM1   = wm1_reg;
    assign bus.WM2   = wm2_reg;
    assign bus.READY = ready_reg;
    assign bus.busy  = (state_reg != S_IDLE);

    // Offset bits, aliased upper address bits and (without forwarding) the
    // upper base bits carry no function here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.A1, bus.A2, bus.WA, base_reg};

endmodule

// File: tb/tb_dmem_refill.sv
// -----------------------------------------------------------------------------
// tb_dmem_refill
// Drives two responders side by side (WAIT_CYC=4 and WAIT_CYC=0) with the same
// stores and per-instance request lines. A timeline model of the refill
// (sampling edge, capture edges WAIT_CYC+1..WAIT_CYC+16, DONE edge) over a
// RAM image predicts READY, busy, WM1 and WM2 every cycle.
// -----------------------------------------------------------------------------
module tb_dmem_refill;

    localparam int DEPTH   = 16384;
    localparam int PRELOAD = 1024;

`ifdef DMEM_REFILL_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_refill_if ifa ();
    dmem_refill_if ifb ();

    logic        req1_d [2];
    logic        req2_d [2];
    logic [31:0] a1_d   [2];
    logic [31:0] a2_d   [2];
    logic        we_d;
    logic [31:0] wa_d;
    logic [31:0] wd_d;

    assign ifa.req1 = req1_d[0];
    assign ifa.req2 = req2_d[0];
    assign ifa.A1   = a1_d[0];
    assign ifa.A2   = a2_d[0];
    assign ifa.WE   = we_d;
    assign ifa.WA   = wa_d;
    assign ifa.WD   = wd_d;
    assign ifb.req1 = req1_d[1];
    assign ifb.req2 = req2_d[1];
    assign ifb.A1   = a1_d[1];
    assign ifb.A2   = a2_d[1];
    assign ifb.WE   = we_d;
    assign ifb.WA   = wa_d;
    assign ifb.WD   = wd_d;

    dmem_refill #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    dmem_refill #(.DEPTH_WORDS(DEPTH), .WAIT_CYC(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    logic [511:0] wm1_o   [2];
    logic [511:0] wm2_o   [2];
    logic         ready_o [2];
    logic         busy_o  [2];
    assign wm1_o[0]   = ifa.WM1;
    assign wm2_o[0]   = ifa.WM2;
    assign ready_o[0] = ifa.READY;
    assign busy_o[0]  = ifa.busy;
    assign wm1_o[1]   = ifb.WM1;
    assign wm2_o[1]   = ifb.WM2;
    assign ready_o[1] = ifb.READY;
    assign busy_o[1]  = ifb.busy;

    // ---------------- reference model ----------------
    int          wait_of [2] = '{4, 0};
    logic [31:0] mem_m [DEPTH];
    bit          p1 [2], p2 [2];          // cache holds these until serviced
    logic [31:0] pa1 [2], pa2 [2];
    bit          m_act [2];
    int          m_edge [2];
    bit          m_port [2];
    logic [25:0] m_base [2];
    logic [31:0] m_line [2][16];
    logic [511:0] exp_wm1 [2], exp_wm2 [2];
    bit          exp_ready [2];
    int          ready_cyc [2][$];
    int          cyc;
    int          n_pass, n_total;

    function automatic logic [511:0] pack_line(input int d);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = m_line[d][i];
        return v;
    endfunction

    // Advance one DUT's timeline by one clock edge. Captures read the RAM
    // image before this edge's store is applied.
    task automatic model_edge(input int d, input bit we, input logic [31:0] wa,
                              input logic [31:0] wd);
        bit          was_act;
        int          w;
        logic [3:0]  wi;
        logic [13:0] ri;
        was_act      = m_act[d];
        w            = wait_of[d];
        exp_ready[d] = 1'b0;
        if (!m_act[d]) begin
            if (p1[d] || p2[d]) begin
                m_act[d]  = 1'b1;
                m_edge[d] = 0;
                m_port[d] = !p1[d];
                m_base[d] = p1[d] ? pa1[d][31:6] : pa2[d][31:6];
            end
        end else begin
            m_edge[d]++;
            if (m_edge[d] >= w + 1 && m_edge[d] <= w + 16) begin
                wi = 4'(m_edge[d] - w - 1);
                ri = {m_base[d][9:0], wi};
                m_line[d][wi] = mem_m[ri];
            end
            if (m_edge[d] == w + 17) m_act[d] = 1'b0;
        end
        if (FWD && we && was_act && wa[31:6] == m_base[d]) m_line[d][wa[5:2]] = wd;
        if (m_act[d] && m_edge[d] == w + 16) begin
            exp_ready[d] = 1'b1;
            if (m_port[d] == 1'b0) begin
                exp_wm1[d] = pack_line(d);
                p1[d] = 1'b0;
            end else begin
                exp_wm2[d] = pack_line(d);
                p2[d] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, edge, model update, check at the falling edge.
    task automatic tick(input bit we, input logic [31:0] wa, input logic [31:0] wd);
        we_d = we;
        wa_d = wa;
        wd_d = wd;
        for (int d = 0; d < 2; d++) begin
            req1_d[d] = p1[d];
            req2_d[d] = p2[d];
            a1_d[d]   = pa1[d];
            a2_d[d]   = pa2[d];
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_edge(d, we, wa, wd);
        if (we) mem_m[wa[15:2]] = wd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (ready_o[d]) ready_cyc[d].push_back(cyc);
            n_total++;
            if (ready_o[d] !== exp_ready[d])
                $display("FAIL ready dut%0d cyc %0d: got %b exp %b", d, cyc, ready_o[d], exp_ready[d]);
            else n_pass++;
            n_total++;
            if (busy_o[d] !== m_act[d])
                $display("FAIL busy dut%0d cyc %0d: got %b exp %b", d, cyc, busy_o[d], m_act[d]);
            else n_pass++;
            n_total++;
            if (wm1_o[d] !== exp_wm1[d])
                $display("FAIL wm1 dut%0d cyc %0d: got %h exp %h", d, cyc, wm1_o[d], exp_wm1[d]);
            else n_pass++;
            n_total++;
            if (wm2_o[d] !== exp_wm2[d])
                $display("FAIL wm2 dut%0d cyc %0d: got %h exp %h", d, cyc, wm2_o[d], exp_wm2[d]);
            else n_pass++;
        end
    endtask

    // Run cycles until both instances are idle with nothing pending.
    // store_t >= 0 issues the given store on that tick; drop_t >= 0 withdraws
    // req1 on that tick; rnd_st issues random stores.
    task automatic run_fill(input int bound, input int store_t, input logic [31:0] st_wa,
                            input logic [31:0] st_wd, input int drop_t, input bit rnd_st);
        int t;
        bit we;
        logic [31:0] wa, wd;
        t = 0;
        while (t < bound && (m_act[0] || m_act[1] || p1[0] || p1[1] || p2[0] || p2[1])) begin
            if (t == drop_t) begin
                p1[0] = 1'b0;
                p1[1] = 1'b0;
            end
            we = 1'b0; wa = '0; wd = '0;
            if (t == store_t) begin
                we = 1'b1; wa = st_wa; wd = st_wd;
            end else if (rnd_st && $urandom_range(0, 2) == 0) begin
                we = 1'b1;
                wd = $urandom;
                if ($urandom_range(0, 1) == 0) wa = {pa1[0][31:6], 4'($urandom_range(0, 15)), 2'b00};
                else wa = {20'd0, 10'($urandom_range(0, PRELOAD - 1)), 2'b00};
                wa[31:12] = '0;
            end
            tick(we, wa, wd);
            t++;
        end
        n_total++;
        if (t >= bound) $display("FAIL fill_timeout: still busy after %0d cycles, want idle", t);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_act[d]     = 1'b0;
            exp_ready[d] = 1'b0;
            exp_wm1[d]   = '0;
            exp_wm2[d]   = '0;
            n_total++;
            if (busy_o[d] !== 1'b0 || ready_o[d] !== 1'b0)
                $display("FAIL reset_ctl dut%0d: busy %b ready %b, want 0 0", d, busy_o[d], ready_o[d]);
            else n_pass++;
            n_total++;
            if (wm1_o[d] !== '0 || wm2_o[d] !== '0)
                $display("FAIL reset_wm dut%0d: wm1 %h wm2 %h, want 0", d, wm1_o[d], wm2_o[d]);
            else n_pass++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_ready_log();
        for (int d = 0; d < 2; d++) ready_cyc[d].delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        do_reset();
    endtask

    task automatic test_preload();
        for (int k = 0; k < PRELOAD; k++)
            tick(1'b1, 32'(k * 4), (k < 64) ? 32'(k) : $urandom);
    endtask

    task automatic test_single();
        int s;
        clear_ready_log();
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h40; end
        s = cyc + 1;
        run_fill(100, -1, '0, '0, -1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (ready_cyc[d].size() != 1 || ready_cyc[d][0] - s != wait_of[d] + 16)
                $display("FAIL single_latency dut%0d: pulses %0d first +%0d, want 1 at +%0d", d,
                         ready_cyc[d].size(), (ready_cyc[d].size() > 0) ? ready_cyc[d][0] - s : -1,
                         wait_of[d] + 16);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (wm1_o[0][32*i +: 32] !== 32'(16 + i))
                $display("FAIL single_word%0d: got %h want %h", i, wm1_o[0][32*i +: 32], 16 + i);
            else n_pass++;
        end
        n_total++;
        if (wm2_o[0] !== '0) $display("FAIL single_wm2: got %h want 0", wm2_o[0]);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        clear_ready_log();
        for (int d = 0; d < 2; d++) begin
            p1[d] = 1'b1; pa1[d] = 32'h0;
            p2[d] = 1'b1; pa2[d] = 32'h80;
        end
        run_fill(200, -1, '0, '0, -1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (ready_cyc[d].size() != 2 || ready_cyc[d][1] - ready_cyc[d][0] != wait_of[d] + 18)
                $display("FAIL arb_gap dut%0d: pulses %0d, want 2 with gap %0d", d,
                         ready_cyc[d].size(), wait_of[d] + 18);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (wm1_o[0][32*i +: 32] !== 32'(i) || wm2_o[0][32*i +: 32] !== 32'(32 + i))
                $display("FAIL arb_word%0d: wm1 %h wm2 %h want %h %h", i, wm1_o[0][32*i +: 32],
                         wm2_o[0][32*i +: 32], i, 32 + i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fill();
        clear_ready_log();
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h100; end
        for (int t = 0; t < 10; t++) tick(1'b0, '0, '0);
        do_reset();
        n_total++;
        if (ready_cyc[0].size() != 0 || ready_cyc[1].size() != 0)
            $display("FAIL reset_abort: ready pulses %0d/%0d before reset, want 0/0",
                     ready_cyc[0].size(), ready_cyc[1].size());
        else n_pass++;
        run_fill(100, -1, '0, '0, -1, 1'b0);
    endtask

    task automatic test_store_after_capture();
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h40; end
        run_fill(100, 7, 32'h44, 32'hDEADBEEF, -1, 1'b0);
        n_total++;
        if (wm1_o[0][63:32] !== (FWD ? 32'hDEADBEEF : 32'd17))
            $display("FAIL store_word1: got %h want %h", wm1_o[0][63:32], FWD ? 32'hDEADBEEF : 32'd17);
        else n_pass++;
        // A second fill shows the store reached RAM in either build.
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h40; end
        run_fill(100, -1, '0, '0, -1, 1'b0);
        n_total++;
        if (wm1_o[0][63:32] !== 32'hDEADBEEF || wm1_o[1][63:32] !== 32'hDEADBEEF)
            $display("FAIL store_ram: got %h/%h want deadbeef", wm1_o[0][63:32], wm1_o[1][63:32]);
        else n_pass++;
    endtask

    task automatic test_same_edge_store();
        // On instance 0 word 5 is captured on edge 10 after sampling.
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h40; end
        run_fill(100, 10, 32'h54, 32'hA5A5_0005, -1, 1'b0);
        n_total++;
        if (wm1_o[0][191:160] !== (FWD ? 32'hA5A5_0005 : 32'd21))
            $display("FAIL same_edge_word5: got %h want %h", wm1_o[0][191:160],
                     FWD ? 32'hA5A5_0005 : 32'd21);
        else n_pass++;
    endtask

    task automatic test_wait0_req_drop();
        int s;
        clear_ready_log();
        for (int d = 0; d < 2; d++) begin p1[d] = 1'b1; pa1[d] = 32'h0; end
        s = cyc + 1;
        run_fill(100, -1, '0, '0, 3, 1'b0);
        n_total++;
        if (ready_cyc[1].size() != 1 || ready_cyc[1][0] != s + 16)
            $display("FAIL wait0_latency: pulses %0d, want 1 at cycle %0d", ready_cyc[1].size(), s + 16);
        else n_pass++;
        n_total++;
        if (ready_cyc[0].size() != 1 || ready_cyc[0][0] != s + 20)
            $display("FAIL drop_latency: pulses %0d, want 1 at cycle %0d", ready_cyc[0].size(), s + 20);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_total++;
            if (wm1_o[1][32*i +: 32] !== 32'(i))
                $display("FAIL wait0_word%0d: got %h want %h", i, wm1_o[1][32*i +: 32], i);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r1, r2;
        bit q1, q2;
        for (int it = 0; it < 25; it++) begin
            q1 = $urandom_range(0, 1) == 1;
            q2 = !q1 || ($urandom_range(0, 1) == 1);
            r1 = {$urandom_range(0, 1) == 1 ? 20'($urandom) : 20'd0, 6'($urandom_range(0, 63)), 6'($urandom)};
            r2 = {20'd0, 6'($urandom_range(0, 63)), 6'($urandom)};
            for (int d = 0; d < 2; d++) begin
                p1[d] = q1; pa1[d] = r1;
                p2[d] = q2; pa2[d] = r2;
            end
            run_fill(200, -1, '0, '0, -1, 1'b1);
        end
    endtask

    initial begin
        cyc = 0; n_pass = 0; n_total = 0;
        we_d = 1'b0; wa_d = '0; wd_d = '0;
        for (int d = 0; d < 2; d++) begin
            p1[d] = 1'b0; p2[d] = 1'b0; pa1[d] = '0; pa2[d] = '0;
            req1_d[d] = 1'b0; req2_d[d] = 1'b0; a1_d[d] = '0; a2_d[d] = '0;
            m_act[d] = 1'b0; m_edge[d] = 0; m_port[d] = 1'b0; m_base[d] = '0;
            exp_wm1[d] = '0; exp_wm2[d] = '0; exp_ready[d] = 1'b0;
        end
        test_reset();
        test_preload();
        test_single();
        test_arbitration();
        test_reset_mid_fill();
        test_store_after_capture();
        test_same_edge_store();
        test_wait0_req_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
